// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
//   in_valid/in_ready : operand channel (a, b, opcode, cin)
//   out_valid/out_ready : result channel (result, result_hi, flag_z/n/c/v)
// master = operand producer / result consumer, slave = the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a, b, opcode, cin, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a, b, opcode, cin, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with flags and a WIDTH-cycle shift-add multiplier.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if.slave (operand handshake in, result handshake out)
// One operation in flight at a time: IDLE accepts, MUL iterates, DONE holds
// the result until the consumer takes it.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e state;
    state_e state_nxt;

    logic [W-1:0]  mcand;
    logic [W-1:0]  prod_hi;
    logic [W-1:0]  prod_lo;
    logic [CW-1:0] iter;

    logic [W-1:0]  res_q;
    logic [W-1:0]  res_hi_q;
    logic          z_q;
    logic          n_q;
    logic          c_q;
    logic          v_q;

    logic          accept_c;
    logic          is_mul_c;
    logic          last_iter_c;

    logic [W-1:0]  b_eff_c;
    logic          carry_in_c;
    logic [W:0]    sum_c;
    logic [W-1:0]  alu_res_c;
    logic          alu_c_c;
    logic          alu_v_c;

    logic [W:0]    mul_add_c;
    logic [W-1:0]  step_hi_c;
    logic [W-1:0]  step_lo_c;

    assign accept_c    = bus.in_valid && (state == IDLE);
    assign is_mul_c    = (op_e'(bus.opcode) == OP_MUL);
    assign last_iter_c = (iter == CW'(W - 1));

    // Single-cycle ALU, evaluated on the live inputs at the accept edge
    always_comb begin
        b_eff_c    = bus.b;
        carry_in_c = bus.cin;
        if (op_e'(bus.opcode) == OP_SUB) begin
            b_eff_c    = ~bus.b;
            carry_in_c = 1'b1;
        end
        sum_c = {1'b0, bus.a} + {1'b0, b_eff_c} + (W + 1)'(carry_in_c);

        alu_res_c = '0;
        alu_c_c   = 1'b0;
        alu_v_c   = 1'b0;
        case (op_e'(bus.opcode))
            OP_ADD, OP_SUB: begin
                alu_res_c = sum_c[W-1:0];
                alu_c_c   = sum_c[W];
                alu_v_c   = (bus.a[W-1] == b_eff_c[W-1]) && (sum_c[W-1] != bus.a[W-1]);
            end
            OP_AND:  alu_res_c = bus.a & bus.b;
            OP_OR:   alu_res_c = bus.a | bus.b;
            OP_XOR:  alu_res_c = bus.a ^ bus.b;
            OP_SHL1: begin
                alu_res_c = {bus.a[W-2:0], bus.cin};
                alu_c_c   = bus.a[W-1];
            end
            OP_SHR1: begin
                alu_res_c = {bus.cin, bus.a[W-1:1]};
                alu_c_c   = bus.a[0];
            end
            default: ;
        endcase
    end

    // One radix-2 shift-add step: conditionally add multiplicand to the high
    // half, then shift the whole {carry, hi, lo} right by one
    always_comb begin
        mul_add_c = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
        step_hi_c = mul_add_c[W:1];
        step_lo_c = {mul_add_c[0], prod_lo[W-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = is_mul_c ? MUL : DONE;
                end
            end
            MUL: begin
                if (last_iter_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier working registers and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
            iter     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            if (accept_c) begin
                if (is_mul_c) begin
                    mcand   <= bus.a;
                    prod_hi <= '0;
                    prod_lo <= bus.b;
                    iter    <= '0;
                end else begin
                    res_q    <= alu_res_c;
                    res_hi_q <= '0;
                    z_q      <= (alu_res_c == '0);
                    n_q      <= alu_res_c[W-1];
                    c_q      <= alu_c_c;
                    v_q      <= alu_v_c;
                end
            end else if (state == MUL) begin
                prod_hi <= step_hi_c;
                prod_lo <= step_lo_c;
                iter    <= iter + CW'(1);
                // The final step's product goes straight into the outputs
                if (last_iter_c) begin
                    res_q    <= step_lo_c;
                    res_hi_q <= step_hi_c;
                    z_q      <= ({step_hi_c, step_lo_c} == '0);
                    n_q      <= step_hi_c[W-1];
                    c_q      <= |step_hi_c;
                    v_q      <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.result_hi = res_hi_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors plus random ops
// against an arithmetic reference model, with random result backpressure.
module tb_alu_seq;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;
    logic bp_rand;
    logic bp_val;

    function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic z, input logic n, input logic c, input logic v);
        exp_t e;
        e.res = r; e.hi = h; e.z = z; e.n = n; e.c = c; e.v = v;
        return e;
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a_i,
                                   input logic [W-1:0] b_i, input logic cin_i);
        longint unsigned m, ua, ub, ci, r, hi, p;
        longint          half, sa, sb, sr;
        logic            c, v, z, n;
        m    = longint'(1) << W;
        half = longint'(m / 2);
        ua   = longint'(a_i);
        ub   = longint'(b_i);
        ci   = longint'(cin_i);
        sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(m) : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(m) : longint'(ub);
        r = 0; hi = 0; p = 0; c = 1'b0; v = 1'b0; sr = 0;
        case (op)
            3'd0: begin
                r  = ua + ub + ci;
                c  = (r >= m);
                r  = r % m;
                sr = sa + sb + longint'(ci);
                v  = (sr < -half) || (sr >= half);
            end
            3'd1: begin
                r  = (ua + m - ub) % m;
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr < -half) || (sr >= half);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin
                r = (ua * 2 + ci) % m;
                c = (longint'(ua) >= half);
            end
            3'd6: begin
                r = ua / 2 + ci * (m / 2);
                c = ((ua % 2) == 1);
            end
            default: begin
                p  = ua * ub;
                r  = p % m;
                hi = p / m;
                c  = (hi != 0);
            end
        endcase
        z = (op == 3'd7) ? (p == 0) : (r == 0);
        n = (op == 3'd7) ? (longint'(hi) >= half) : (longint'(r) >= half);
        return mk(W'(r), W'(hi), z, n, c, v);
    endfunction

    task automatic cmp(input string name, input exp_t act, input exp_t e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got res=%h hi=%h znvc=%b%b%b%b, expected res=%h hi=%h znvc=%b%b%b%b",
                     name, act.res, act.hi, act.z, act.n, act.c, act.v,
                     e.res, e.hi, e.z, e.n, e.c, e.v);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, e);
        end
    endtask

    function automatic exp_t dut_out();
        return mk(bus.result, bus.result_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v);
    endfunction

    // Pops an expectation on every handshake; checks hold stability while stalled
    task automatic monitor();
        exp_t held;
        exp_t cur;
        exp_t e;
        logic held_ok;
        held_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_ok = 1'b0;
            end else if (bus.out_valid) begin
                cur = dut_out();
                if (held_ok) cmp("hold_stable", cur, held);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_output: got res=%h hi=%h, expected no output",
                                 cur.res, cur.hi);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("result", cur, e);
                    end
                    held_ok = 1'b0;
                end else begin
                    held    = cur;
                    held_ok = 1'b1;
                end
            end else begin
                held_ok = 1'b0;
            end
        end
    endtask

    task automatic bp_driver();
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_rand ? ($urandom_range(3) != 0) : bp_val;
        end
    endtask

    // Present one operation; called at posedge+1, returns at posedge+1 after accept
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a_i,
                         input logic [W-1:0] b_i, input logic cin_i, input exp_t e);
        int waited;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a_i;
        bus.b        = b_i;
        bus.cin      = cin_i;
        waited       = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.a        = $urandom();
                bus.b        = $urandom();
                break;
            end
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected accept", waited);
                bus.in_valid = 1'b0;
                break;
            end
        end
    endtask

    // Cycles from the accept edge until out_valid is seen (1 = next cycle)
    task automatic latency(input string name, input int expect_cyc, input logic chk_busy);
        int cyc;
        cyc = 1;
        @(negedge clk);
        while (!bus.out_valid && cyc < 100) begin
            if (chk_busy) chk({name, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(expect_cyc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drain;
        logic [2:0] op;
        logic [W-1:0] ra, rb;
        logic rc;

        n_vec        = 0;
        n_bad        = 0;
        bp_rand      = 1'b0;
        bp_val       = 1'b1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.opcode   = '0;
        bus.cin      = 1'b0;
        bus.out_ready = 1'b1;

        fork
            monitor();
            bp_driver();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset_outputs", dut_out(), mk('0, '0, 0, 0, 0, 0));
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expectations
        issue(3'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 8'h00, 1, 0, 1, 0));
        latency("add", 1, 1'b0);
        issue(3'd1, 8'h80, 8'h01, 1'b1, mk(8'h7F, 8'h00, 0, 0, 1, 1));
        latency("sub_ovf", 1, 1'b0);
        issue(3'd1, 8'h01, 8'h02, 1'b0, mk(8'hFF, 8'h00, 0, 1, 0, 0));
        issue(3'd7, 8'hFF, 8'hFF, 1'b0, mk(8'h01, 8'hFE, 0, 1, 1, 0));
        latency("mul_ff", W + 1, 1'b1);
        issue(3'd7, 8'h00, 8'h37, 1'b0, mk(8'h00, 8'h00, 1, 0, 0, 0));
        latency("mul_zero", W + 1, 1'b1);
        issue(3'd5, 8'h81, 8'h00, 1'b1, mk(8'h03, 8'h00, 0, 0, 1, 0));
        issue(3'd6, 8'h01, 8'h00, 1'b1, mk(8'h80, 8'h00, 0, 1, 1, 0));
        issue(3'd4, 8'hAA, 8'hAA, 1'b0, mk(8'h00, 8'h00, 1, 0, 0, 0));

        // Backpressure: result stalls 5 cycles while the next op waits at the input
        repeat (3) @(posedge clk);
        bp_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                issue(3'd0, 8'h12, 8'h34, 1'b1, mk(8'h47, 8'h00, 0, 0, 0, 0));
                issue(3'd4, 8'h0F, 8'hF0, 1'b0, mk(8'hFF, 8'h00, 0, 1, 0, 0));
            end
            begin
                drain = 0;
                @(negedge clk);
                while (!bus.out_valid && drain < 50) begin
                    @(negedge clk);
                    drain++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    @(negedge clk);
                end
                bp_val = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset during MUL iteration 4: aborted op must never emit
        issue(3'd7, 8'h5A, 8'h3C, 1'b0, model(3'd7, 8'h5A, 8'h3C, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        cmp("abort_outputs", dut_out(), mk('0, '0, 0, 0, 0, 0));
        repeat (20) @(posedge clk);
        #1;

        // Random ops against the reference model, random backpressure and gaps
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(7));
            ra = W'($urandom());
            rb = W'($urandom());
            rc = 1'($urandom_range(1));
            if (i % 10 == 0) ra = (i % 20 == 0) ? '0 : '1;
            issue(op, ra, rb, rc, model(op, ra, rb, rc));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        bp_rand = 1'b0;
        bp_val  = 1'b1;
        drain   = 0;
        while (exp_q.size() > 0 && drain < 2000) begin
            @(negedge clk);
            drain++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 4-bit ripple ALU.
- Widens the datapath to WIDTH bits and adds XOR, shift-by-one and unsigned multiply operations.
- Produces a flag set (zero, negative, carry, overflow).
- Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake with backpressure.
- Single-cycle operations complete in 1 cycle. Multiply is a WIDTH-cycle shift-add sequence, used by the datapath controller wherever a bounded-area ALU is needed.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  3  operation select.
- cin  input  1  carry/shift-in bit.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  result, low half for MUL.
- result_hi  output  WIDTH  high half of MUL product; 0 for all other ops.
- flag_z  output  1  zero flag.
- flag_n  output  1  negative flag.
- flag_c  output  1  carry flag.
- flag_v  output  1  overflow flag.

Behaviour:
- Reset: rst_n sampled low at a rising edge puts the block in IDLE and clears result, result_hi, all flags and out_valid to 0. in_ready=1 from the first edge after reset releases. Reset mid-operation aborts a MUL in progress and drops any pending result without further output.
- States: IDLE, MUL, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: when in_valid && in_ready at an edge, a/b/opcode/cin are captured. Inputs are don't-care at all other times.
- Opcodes (ALU ops complete in 1 cycle; IDLE->DONE at accept edge, out_valid high the next cycle):
  - 000 ADD: {c,result} = a + b + cin.
  - 001 SUB: {c,result} = a + ~b + 1; cin ignored; c=1 means no borrow (a>=b unsigned).
  - 010 AND; 011 OR; 100 XOR: c=0, v=0.
  - 101 SHL1: result = {a[WIDTH-2:0],cin}, c = a[WIDTH-1], v=0.
  - 110 SHR1: result = {cin,a[WIDTH-1:1]}, c = a[0], v=0.
  - 111 MUL: unsigned a*b, radix-2 shift-add over exactly WIDTH cycles in state MUL, then DONE. out_valid is high WIDTH+1 cycles after the accept edge. {result_hi,result} = full 2*WIDTH product. c = |result_hi, v=0.
- Flags:
  - z = (result==0); for MUL, z = (product==0).
  - n = MSB of result (of result_hi for MUL).
  - v for ADD/SUB = signed overflow: operand signs equal (B inverted for SUB) and result sign differs.
- DONE: result/result_hi/flags hold stable while out_valid && !out_ready. The out_valid && out_ready edge moves the block to IDLE, so in_ready rises the next cycle. No overlap: at most one operation in flight; back-to-back ALU ops sustain one op per 2 cycles.
- Output registers change only at the DONE entry edge and on reset; they are not modified during MUL iterations.
- Unused upper result_hi bits are 0 for non-MUL ops.

Test Plan (WIDTH=8):
- Reset, then ADD a=0xFF b=0x01 cin=0 -> next cycle out_valid=1, result=0x00, z=1, c=1, v=0, n=0.
- SUB a=0x80 b=0x01 -> result=0x7F, c=1, v=1, n=0. SUB a=0x01 b=0x02 -> result=0xFF, c=0, n=1, v=0.
- MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result_hi=0xFE, result=0x01, c=1, in_ready=0 throughout. MUL a=0 b=0x37 -> z=1, c=0.
- SHL1 a=0x81 cin=1 -> result=0x03, c=1. SHR1 a=0x01 cin=1 -> result=0x80, c=1, n=1. XOR a=0xAA b=0xAA -> z=1.
- Backpressure: complete ADD with out_ready=0 for 5 cycles, in_valid held high with new operands -> outputs stable, in_ready=0, the new op is accepted only after the out_ready handshake.
- Assert rst_n=0 for one cycle at MUL iteration 4 -> next cycle out_valid=0, all outputs 0, in_ready=1; no result ever emitted for the aborted op.
